// File: rtl/spi_mult_pkg.sv
// Shared types and sizing helpers for the SPI slave multiplier.
package spi_mult_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RECV = 3'd1,
    MULT = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_t;

  // Bits per direction in one frame: both operands in, the product out.
  function automatic int frame_len(input int width);
    return 2 * width;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(2 * width + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with registered
// rise/fall strobes and a synchronised level aligned to those strobes.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_q;
  logic                   rise_q;
  logic                   fall_q;

  // Synchroniser chain plus edge detection on its last stage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      lvl_q  <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~lvl_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & lvl_q;
    end
  end

  assign q_o    = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_mult_slave.sv
// SPI mode-0 slave: receives A and B, multiplies with a sequential
// shift-add datapath, and returns the 2*WIDTH-bit product in the same frame.
module spi_mult_slave
  import spi_mult_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SIGNED      = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SCLK,
  input  logic MOSI,
  input  logic CS,
  output logic MISO,
  output logic MISO_OE,
  output logic busy,
  output logic done,
  output logic overrun
);

  localparam int PW = frame_len(WIDTH);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT  = CW'(PW - 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic sclk_rise_s, sclk_fall_s, sclk_lvl_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic cs_s, cs_rise_s, cs_fall_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i(CLK), .rst_n_i(RST_N), .d_i(SCLK),
    .q_o(sclk_lvl_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk_i(CLK), .rst_n_i(RST_N), .d_i(MOSI),
    .q_o(mosi_s), .rise_o(mosi_rise_s), .fall_o(mosi_fall_s)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i(CLK), .rst_n_i(RST_N), .d_i(CS),
    .q_o(cs_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s)
  );

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   in_q, in_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   out_q, out_d;
  logic            ovr_q, ovr_d;

  logic            sign_s;
  logic [PW-1:0]   a_ext_s;
  logic [PW-1:0]   pp_s;
  logic            b_bit_s;
  logic            sub_s;

  // A occupies the upper half of the input register, B the lower half.
  assign sign_s  = (SIGNED != 0) & in_q[PW-1];
  assign a_ext_s = {{WIDTH{sign_s}}, in_q[PW-1:WIDTH]};
  assign pp_s    = a_ext_s << cnt_q;
  assign b_bit_s = in_q[cnt_q];
  assign sub_s   = (SIGNED != 0) && (cnt_q == LAST_ITER);

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state and datapath update; a CS rise always takes priority.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    acc_d   = acc_q;
    out_d   = out_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (cs_fall_s) begin
          cnt_d   = '0;
          ovr_d   = 1'b0;
          state_d = RECV;
        end else begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (cs_rise_s) begin
          in_d    = '0;
          state_d = IDLE;
        end else if (sclk_rise_s) begin
          in_d = {in_q[PW-2:0], mosi_s};
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            acc_d   = '0;
            state_d = MULT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = RECV;
        end
      end
      MULT: begin
        if (cs_rise_s) begin
          in_d    = '0;
          state_d = IDLE;
        end else begin
          if (sclk_rise_s) begin
            ovr_d = 1'b1;
          end else begin
            ovr_d = ovr_q;
          end
          if (b_bit_s) begin
            acc_d = sub_s ? (acc_q - pp_s) : (acc_q + pp_s);
          end else begin
            acc_d = acc_q;
          end
          if (cnt_q == LAST_ITER) begin
            out_d   = acc_d;
            cnt_d   = '0;
            state_d = SEND;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      SEND: begin
        if (cs_rise_s) begin
          state_d = IDLE;
        end else if (sclk_rise_s) begin
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = FIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (sclk_fall_s && (cnt_q != '0)) begin
          // The trailing fall of the last input bit must not shift out the MSB.
          out_d = {out_q[PW-2:0], 1'b0};
        end else begin
          state_d = SEND;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign MISO_OE = (state_q == SEND) && !cs_s;
  assign MISO    = MISO_OE & out_q[PW-1];
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);
  assign overrun = ovr_q;

endmodule

// File: tb/tb_spi_mult_slave.sv
// Scoreboard bench: three slaves (4-bit unsigned, 4-bit signed, 8-bit
// unsigned) share SCLK/MOSI/RST_N and are selected by their own CS.
module tb_spi_mult_slave;

  localparam int HI  = 6;
  localparam int LO  = 6;
  localparam int GAP = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic [2:0] cs = 3'b111;
  logic [2:0] miso_w, oe_w, busy_w, done_w, ovr_w;

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int done_cnt [3] = '{0, 0, 0};
  logic [31:0] exp_q [$];
  logic miso_s, oe_s, busy_s, ovr_s;

  always #5 clk = ~clk;

  spi_mult_slave #(.WIDTH(4), .SIGNED(0), .SYNC_STAGES(2)) u_dut_4u (
    .CLK(clk), .RST_N(rst_n), .SCLK(sclk), .MOSI(mosi), .CS(cs[0]),
    .MISO(miso_w[0]), .MISO_OE(oe_w[0]), .busy(busy_w[0]), .done(done_w[0]), .overrun(ovr_w[0])
  );
  spi_mult_slave #(.WIDTH(4), .SIGNED(1), .SYNC_STAGES(2)) u_dut_4s (
    .CLK(clk), .RST_N(rst_n), .SCLK(sclk), .MOSI(mosi), .CS(cs[1]),
    .MISO(miso_w[1]), .MISO_OE(oe_w[1]), .busy(busy_w[1]), .done(done_w[1]), .overrun(ovr_w[1])
  );
  spi_mult_slave #(.WIDTH(8), .SIGNED(0), .SYNC_STAGES(2)) u_dut_8u (
    .CLK(clk), .RST_N(rst_n), .SCLK(sclk), .MOSI(mosi), .CS(cs[2]),
    .MISO(miso_w[2]), .MISO_OE(oe_w[2]), .busy(busy_w[2]), .done(done_w[2]), .overrun(ovr_w[2])
  );

  // Selected-slave view of the outputs.
  always_comb begin
    miso_s = miso_w[sel];
    oe_s   = oe_w[sel];
    busy_s = busy_w[sel];
    ovr_s  = ovr_w[sel];
  end

  // Count done pulses per slave.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_w[k]) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] model(input int s, input logic [15:0] a, input logic [15:0] b);
    int w, ai, bi;
    longint p;
    w  = (s == 2) ? 8 : 4;
    ai = int'(a) & ((1 << w) - 1);
    bi = int'(b) & ((1 << w) - 1);
    if (s == 1) begin
      if (ai >= (1 << (w - 1))) ai = ai - (1 << w);
      if (bi >= (1 << (w - 1))) bi = bi - (1 << w);
    end
    p = longint'(ai) * longint'(bi);
    return 32'(p & ((64'd1 << (2 * w)) - 64'd1));
  endfunction

  // mode: 0 normal, 1 extra SCLK rise during MULT, 2 abort after 5 bits, 3 reset during MULT
  task automatic frame(input int s, input logic [15:0] a, input logic [15:0] b, input int mode);
    int w, d0;
    logic [31:0] word, got, exp;
    logic oe_all;
    sel  = s;
    w    = (s == 2) ? 8 : 4;
    word = ((32'(a) & ((32'd1 << w) - 32'd1)) << w) | (32'(b) & ((32'd1 << w) - 32'd1));
    got  = 32'd0;
    oe_all = 1'b1;
    d0   = done_cnt[s];
    if (mode < 2) exp_q.push_back(model(s, a, b));
    cs[s] = 1'b0;
    cyc(6);
    for (int i = 2 * w - 1; i >= 0; i--) begin
      if (mode == 2 && i == 2 * w - 6) break;
      mosi = word[i];
      cyc(LO);
      if (i == 2 * w - 1) check_eq("oe_recv", 32'(oe_s), 32'd0);
      sclk = 1'b1;
      if (i == 0 && mode == 1) begin
        cyc(1); sclk = 1'b0; cyc(1); sclk = 1'b1; cyc(1);
      end else if (i == 0 && mode == 3) begin
        cyc(5);
        check_eq("busy_mult", 32'(busy_s), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async", {27'd0, miso_s, oe_s, busy_s, done_w[s], ovr_s}, 32'd0);
      end else begin
        cyc(HI);
      end
      sclk = 1'b0;
    end
    if (mode == 3) begin
      cs[s] = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(3);
      return;
    end
    if (mode == 2) begin
      cs[s] = 1'b1;
      cyc(8);
      check_eq("abort_idle", 32'(busy_s), 32'd0);
      check_eq("abort_nodone", 32'(done_cnt[s] - d0), 32'd0);
      return;
    end
    cyc(GAP);
    for (int i = 2 * w - 1; i >= 0; i--) begin
      cyc(LO);
      oe_all = oe_all & oe_s;
      got[i] = miso_s;
      sclk = 1'b1;
      cyc(HI);
      sclk = 1'b0;
    end
    cyc(6);
    check_eq("oe_send", 32'(oe_all), 32'd1);
    check_eq("oe_after", 32'(oe_s), 32'd0);
    check_eq("busy_after", 32'(busy_s), 32'd0);
    check_eq("done_pulse", 32'(done_cnt[s] - d0), 32'd1);
    check_eq("overrun", 32'(ovr_s), (mode == 1) ? 32'd1 : 32'd0);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check_eq("product", got, exp);
    end
    cs[s] = 1'b1;
    cyc(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(4);
    for (int k = 0; k < 3; k++) begin
      check_eq("reset", {27'd0, miso_w[k], oe_w[k], busy_w[k], done_w[k], ovr_w[k]}, 32'd0);
    end
    rst_n = 1'b1;
    cyc(6);

    frame(0, 16'hB, 16'h6, 0);
    frame(1, 16'hB, 16'h6, 0);
    frame(1, 16'h8, 16'h8, 0);
    frame(2, 16'hFF, 16'hFF, 0);
    frame(0, 16'h9, 16'h7, 1);
    frame(0, 16'h2, 16'h3, 0);
    frame(0, 16'hA, 16'hC, 2);
    frame(0, 16'h3, 16'h5, 0);
    frame(0, 16'h7, 16'h9, 3);
    frame(0, 16'hD, 16'hE, 0);
    for (int r = 0; r < 3; r++) begin
      frame(0, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), 0);
      frame(1, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), 0);
      frame(2, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
